// File: rtl/pc_branch_pkg.sv
// Shared types for the fetch-PC / branch resolution unit: branch conditions,
// FSM states and instruction size.
package pc_branch_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_funct3_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int INSN_BYTES = 4;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: funct3 selects the rs1/rs2 compare.
module branch_cmp
  import pc_branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (funct3)
      BR_EQ:   cond_true = (rs1 == rs2);
      BR_NE:   cond_true = (rs1 != rs2);
      BR_LT:   cond_true = ($signed(rs1) < $signed(rs2));
      BR_GE:   cond_true = ($signed(rs1) >= $signed(rs2));
      BR_LTU:  cond_true = (rs1 < rs2);
      BR_GEU:  cond_true = (rs1 >= rs2);
      default: cond_true = 1'b0;  // 010/011 are not branch encodings
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch-PC register plus branch/jump resolution with a wrong-path squash window.
// Define BRANCH_PERF_EN to add saturating branch/taken event counters.
module pc_branch_unit
  import pc_branch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter logic [XLEN-1:0] TRAP_PC      = XLEN'('h100),
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic            ex_jal_i,
  input  logic            ex_jalr_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic [XLEN-1:0] ex_imm_i,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            flush_o,
  output logic            ex_taken_o,
  output logic [XLEN-1:0] link_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] trap_addr_o,
  output state_e          dbg_state_o
`ifdef BRANCH_PERF_EN
  ,
  output logic [63:0]     br_cnt_o,
  output logic [63:0]     taken_cnt_o
`endif
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSN_BYTES);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] pc;
  logic            fv;
  logic            mis;
  logic [XLEN-1:0] trap_addr;
  logic            accepted;
  logic            cond_true;
  logic            taken;
  logic [XLEN-1:0] target;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3    (ex_funct3_i),
    .rs1       (ex_rs1_i),
    .rs2       (ex_rs2_i),
    .cond_true (cond_true)
  );

  // Handshake: fetch_valid_o qualifies pc_o each cycle (no back-pressure other
  // than stall_i); ex_valid_i qualifies ex_* and is only consumed in RUN.
  assign accepted = ex_valid_i && (state == RUN);
  assign taken    = accepted && (ex_jal_i || ex_jalr_i || (ex_branch_i && cond_true));

  always_comb begin
    target = ex_pc_i + ex_imm_i;
    if (!ex_jal_i && ex_jalr_i) target = (ex_rs1_i + ex_imm_i) & ~XLEN'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      pc        <= RESET_PC;
      fv        <= 1'b0;
      mis       <= 1'b0;
      trap_addr <= '0;
    end else begin
      fv  <= 1'b1;
      mis <= 1'b0;
      if (taken) begin
        state <= FLUSH;
        cnt   <= CW'(FLUSH_CYCLES - 1);
        if (target[1]) begin
          pc        <= TRAP_PC;
          mis       <= 1'b1;
          trap_addr <= target;
        end else begin
          pc <= target;
        end
      end else if (state == FLUSH) begin
        if (!stall_i) begin
          pc <= pc + STEP;
          if (cnt == '0) state <= RUN;
          else cnt <= cnt - CW'(1);
        end
      end else if (!stall_i && fv) begin
        // The first cycle out of reset presents RESET_PC itself as a valid fetch.
        pc <= pc + STEP;
      end
    end
  end

  assign pc_o          = pc;
  assign fetch_valid_o = fv;
  assign flush_o       = (state == FLUSH);
  assign ex_taken_o    = taken;
  assign link_o        = ex_pc_i + STEP;
  assign misalign_o    = mis;
  assign trap_addr_o   = trap_addr;
  assign dbg_state_o   = state;

`ifdef BRANCH_PERF_EN
  logic [63:0] br_cnt;
  logic [63:0] taken_cnt;
  logic        ctrl;

  assign ctrl = ex_branch_i || ex_jal_i || ex_jalr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      if (accepted && ctrl && (br_cnt != '1)) br_cnt <= br_cnt + 64'd1;
      if (taken && (taken_cnt != '1)) taken_cnt <= taken_cnt + 64'd1;
    end
  end

  assign br_cnt_o    = br_cnt;
  assign taken_cnt_o = taken_cnt;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed plus randomized bench for pc_branch_unit against a cycle-level
// reference model of fetch PC, squash window and trap behaviour.
module tb_pc_branch_unit;
  import pc_branch_pkg::*;

  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h40;
  localparam logic [31:0] TPC  = 32'h100;
  localparam int          FC   = 2;

  logic        clk, rst, stall;
  logic        ex_valid, ex_branch, ex_jal, ex_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic [31:0] pc_o, link_o, trap_addr_o;
  logic        fetch_valid_o, flush_o, ex_taken_o, misalign_o;
  state_e      dbg_state_o;
`ifdef BRANCH_PERF_EN
  logic [63:0] br_cnt_o, taken_cnt_o;
  longint unsigned m_br, m_tk;
`endif

  pc_branch_unit #(
    .XLEN(XLEN), .RESET_PC(RPC), .TRAP_PC(TPC), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .ex_valid_i(ex_valid), .ex_branch_i(ex_branch), .ex_jal_i(ex_jal),
    .ex_jalr_i(ex_jalr), .ex_funct3_i(ex_funct3), .ex_pc_i(ex_pc),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_imm_i(ex_imm),
    .pc_o(pc_o), .fetch_valid_o(fetch_valid_o), .flush_o(flush_o),
    .ex_taken_o(ex_taken_o), .link_o(link_o), .misalign_o(misalign_o),
    .trap_addr_o(trap_addr_o), .dbg_state_o(dbg_state_o)
`ifdef BRANCH_PERF_EN
    , .br_cnt_o(br_cnt_o), .taken_cnt_o(taken_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: fetch PC, squash cycles still owed, trap state.
  logic [31:0] m_pc, m_trap;
  logic        m_fv, m_mis;
  int          m_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return ua < ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_taken();
    if (!ex_valid || m_left > 0) return 1'b0;
    if (ex_jal || ex_jalr) return 1'b1;
    return ex_branch && ref_cond(ex_funct3, ex_rs1, ex_rs2);
  endfunction

  function automatic logic [31:0] ref_target();
    logic [31:0] t;
    if (!ex_jal && ex_jalr) begin
      t = ex_rs1 + ex_imm;
      t[0] = 1'b0;
    end else begin
      t = ex_pc + ex_imm;
    end
    return t;
  endfunction

  task automatic tick();
    logic        tk;
    logic [31:0] tgt;
    bit          acc_ctrl;
    #1;
    tk       = ref_taken();
    tgt      = ref_target();
    acc_ctrl = ex_valid && (m_left == 0) && (ex_branch || ex_jal || ex_jalr);
    if (!rst) begin
      chk("ex_taken", ex_taken_o, tk);
      chk("link", link_o, ex_pc + 32'd4);
    end
    @(posedge clk);
    if (rst) begin
      m_pc = RPC; m_fv = 0; m_left = 0; m_trap = 0; m_mis = 0;
`ifdef BRANCH_PERF_EN
      m_br = 0; m_tk = 0;
`endif
    end else begin
`ifdef BRANCH_PERF_EN
      if (acc_ctrl && m_br != 64'hFFFF_FFFF_FFFF_FFFF) m_br++;
      if (tk && m_tk != 64'hFFFF_FFFF_FFFF_FFFF) m_tk++;
`endif
      m_mis = 0;
      if (tk) begin
        if (tgt[1]) begin m_pc = TPC; m_mis = 1; m_trap = tgt; end
        else m_pc = tgt;
        m_left = FC;
      end else if (m_left > 0) begin
        if (!stall) begin m_pc += 32'd4; m_left--; end
      end else if (!stall && m_fv) begin
        m_pc += 32'd4;
      end
      m_fv = 1;
    end
    #1;
    chk("pc", pc_o, m_pc);
    chk("fetch_valid", fetch_valid_o, m_fv);
    chk("flush", flush_o, m_left > 0);
    chk("misalign", misalign_o, m_mis);
    chk("trap_addr", trap_addr_o, m_trap);
    chk("state", logic'(dbg_state_o), m_left > 0);
`ifdef BRANCH_PERF_EN
    chk("br_cnt", br_cnt_o, m_br);
    chk("taken_cnt", taken_cnt_o, m_tk);
`endif
  endtask

  task automatic idle();
    ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
  endtask

  task automatic set_br(input logic [2:0] f, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm);
    ex_valid = 1; ex_branch = 1; ex_jal = 0; ex_jalr = 0;
    ex_funct3 = f; ex_pc = p; ex_rs1 = a; ex_rs2 = b; ex_imm = imm;
  endtask

  task automatic set_jal(input logic [31:0] p, input logic [31:0] imm);
    ex_valid = 1; ex_branch = 0; ex_jal = 1; ex_jalr = 0;
    ex_pc = p; ex_imm = imm;
  endtask

  task automatic set_jalr(input logic [31:0] p, input logic [31:0] a, input logic [31:0] imm);
    ex_valid = 1; ex_branch = 0; ex_jal = 0; ex_jalr = 1;
    ex_pc = p; ex_rs1 = a; ex_imm = imm;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; stall = 0; idle();
    ex_funct3 = 0; ex_pc = 0; ex_rs1 = 0; ex_rs2 = 0; ex_imm = 0;
    m_pc = 0; m_trap = 0; m_fv = 0; m_mis = 0; m_left = 0;

    // Reset and first fetches
    repeat (3) tick();
    chk("reset_pc", pc_o, RPC);
    chk("reset_fv", fetch_valid_o, 0);
    rst = 0;
    tick();
    chk("first_fetch_fv", fetch_valid_o, 1);
    chk("first_fetch_pc", pc_o, 32'h40);
    tick();
    chk("second_fetch_pc", pc_o, 32'h44);

    // BLT signed: -1 < 1 taken
    set_br(3'b100, 32'h80, 32'hFFFF_FFFF, 32'h1, 32'h10);
    tick();
    chk("blt_pc", pc_o, 32'h90);
    chk("blt_flush1", flush_o, 1);
    idle();
    tick();
    chk("blt_flush2", flush_o, 1);
    tick();
    chk("blt_flush_end", flush_o, 0);
    chk("blt_pc_after", pc_o, 32'h98);

    // BLTU: 0xFFFFFFFF < 1 false
    set_br(3'b110, 32'h80, 32'hFFFF_FFFF, 32'h1, 32'h10);
    tick();
    chk("bltu_pc", pc_o, 32'h9C);
    chk("bltu_flush", flush_o, 0);

    // JALR aligned and misaligned
    set_jalr(32'h300, 32'h201, 32'h0);
    #1;
    chk("jalr_link", link_o, 32'h304);
    tick();
    chk("jalr_pc", pc_o, 32'h200);
    idle();
    repeat (2) tick();
    set_jalr(32'h300, 32'h201, 32'h2);
    tick();
    chk("mis_pulse", misalign_o, 1);
    chk("mis_pc", pc_o, TPC);
    chk("mis_addr", trap_addr_o, 32'h202);
    idle();
    tick();
    chk("mis_pulse_end", misalign_o, 0);
    chk("mis_addr_held", trap_addr_o, 32'h202);
    tick();

    // Taken branch offered during FLUSH is ignored
    set_jal(32'h400, 32'h20);
    tick();
    chk("jal_pc", pc_o, 32'h420);
    set_br(3'b000, 32'h500, 32'h5, 32'h5, 32'h40);
    #1;
    chk("taken_in_flush", ex_taken_o, 0);
    tick();
    chk("flush_ignore_pc", pc_o, 32'h424);
    idle();
    tick();

    // Stall during FLUSH holds pc and extends the window
    set_jal(32'h600, 32'h8);
    tick();
    idle();
    stall = 1;
    repeat (2) tick();
    chk("stall_pc", pc_o, 32'h608);
    chk("stall_flush", flush_o, 1);
    stall = 0;
    tick();
    chk("unstall_pc", pc_o, 32'h60C);
    chk("unstall_flush", flush_o, 1);
    tick();
    chk("unstall_done", flush_o, 0);

    // PC wrap at 2^32
    set_jal(32'hFFFF_FFF0, 32'hC);
    tick();
    idle();
    tick();
    chk("wrap_pc", pc_o, 32'h0);
    tick();

    // Reset mid-FLUSH
    set_jal(32'h700, 32'h0);
    tick();
    idle();
    rst = 1;
    tick();
    chk("rst_flush_pc", pc_o, RPC);
    chk("rst_flush_flush", flush_o, 0);
    chk("rst_flush_state", logic'(dbg_state_o), 0);
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      ex_valid  = ($urandom_range(0, 3) != 0);
      ex_branch = 1'($urandom_range(0, 1));
      ex_jal    = ($urandom_range(0, 5) == 0);
      ex_jalr   = ($urandom_range(0, 4) == 0);
      ex_funct3 = 3'($urandom_range(0, 7));
      ex_rs1    = pick();
      ex_rs2    = ($urandom_range(0, 3) == 0) ? ex_rs1 : pick();
      ex_imm    = 32'($urandom_range(0, 63) * 4) - 32'd128;
      if ($urandom_range(0, 7) == 0) ex_imm[1] = 1'b1;
      ex_pc     = $urandom & ~32'h3;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
